// File: rtl/serial_nibble_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per clock through a 4-bit ripple-carry adder, LSB first.
// Optional subtract mode is compiled in with `define SUBTRACT_EN.

module rca4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       carry
);

  logic [4:0] c;

  always_comb begin
    sum = '0;
    c   = {4'b0000, cin};
    for (int i = 0; i < 4; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    carry = c[4];
  end

endmodule

module serial_nibble_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef SUBTRACT_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             busy
);

  localparam int NIB   = WIDTH / 4;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

  generate
    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
      $error("serial_nibble_adder: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             accept;
  logic [CNT_W+1:0] bit_idx;
  logic [3:0]       a_nib, b_nib, nib_sum;
  logic             nib_carry;
  logic             cin_first;
`ifdef SUBTRACT_EN
  logic             sub_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (cnt_q == LAST) state_d = S_DONE;
      end
      S_DONE: begin
        busy = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign accept  = in_valid & in_ready;
  assign bit_idx = {cnt_q, 2'b00};
  assign a_nib   = a_q[bit_idx +: 4];

  // Subtraction is A + ~B + 1: invert B nibbles and force the first carry-in.
`ifdef SUBTRACT_EN
  assign b_nib     = b_q[bit_idx +: 4] ^ {4{sub_q}};
  assign cin_first = in_sub | in_cin;
`else
  assign b_nib     = b_q[bit_idx +: 4];
  assign cin_first = in_cin;
`endif

  rca4 u_rca (
    .a     (a_nib),
    .b     (b_nib),
    .cin   (carry_q),
    .sum   (nib_sum),
    .carry (nib_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      out_sum   <= '0;
      out_carry <= 1'b0;
      out_valid <= 1'b0;
`ifdef SUBTRACT_EN
      sub_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            a_q     <= in_a;
            b_q     <= in_b;
            carry_q <= cin_first;
            cnt_q   <= '0;
`ifdef SUBTRACT_EN
            sub_q   <= in_sub;
`endif
          end
        end
        S_RUN: begin
          out_sum[bit_idx +: 4] <= nib_sum;
          carry_q               <= nib_carry;
          cnt_q                 <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            out_carry <= nib_carry;
            out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Directed and random checks for serial_nibble_adder at WIDTH=16.
// Subtract scenarios are included when SUBTRACT_EN is defined.

module tb_serial_nibble_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a, in_b;
  logic         in_cin;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_carry;
  logic         busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_nibble_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef SUBTRACT_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .busy      (busy)
  );

  // Present operands and return #1 after the accepting edge; ok=0 if never ready.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, output logic ok);
    int n;
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    ok = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Edges counted from the accepting edge to out_valid; -1 on timeout.
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!out_valid) n = -1;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (out_sum !== 16'h0000) begin bad++; $display("FAIL reset_out_sum got=%h exp=0000", out_sum); end
    total++; if (out_carry !== 1'b0) begin bad++; $display("FAIL reset_out_carry got=%b exp=0", out_carry); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_carry_ripple();
    logic ok; int n;
    start_op(16'hFFFF, 16'h0001, 1'b0, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL ripple_accept got=%b exp=1", ok); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ripple_early_valid got=%b exp=0", out_valid); end
    wait_valid(n);
    total++; if (n != 4) begin bad++; $display("FAIL ripple_latency got=%0d exp=4", n); end
    total++; if (out_sum !== 16'h0000) begin bad++; $display("FAIL ripple_sum got=%h exp=0000", out_sum); end
    total++; if (out_carry !== 1'b1) begin bad++; $display("FAIL ripple_carry got=%b exp=1", out_carry); end
    release_result();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++;
      $display("FAIL ripple_release got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready); end
  endtask

  task automatic test_basic_busy();
    logic ok, seen_bad; int n;
    start_op(16'h1234, 16'h4321, 1'b1, ok);
    n = 0; seen_bad = 1'b0;
    while (!out_valid && n < 20) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) seen_bad = 1'b1;
      @(posedge clk); #1; n++;
    end
    total++; if (seen_bad !== 1'b0) begin bad++; $display("FAIL busy_run_flags got=%b exp=0", seen_bad); end
    total++; if (n != 4) begin bad++; $display("FAIL busy_latency got=%0d exp=4", n); end
    total++; if (busy !== 1'b1 || in_ready !== 1'b0) begin bad++;
      $display("FAIL busy_done got busy=%b ready=%b exp busy=1 ready=0", busy, in_ready); end
    total++; if ({out_carry, out_sum} !== 17'h05556) begin bad++;
      $display("FAIL basic_result got=%b_%h exp=0_5556", out_carry, out_sum); end
    release_result();
  endtask

  task automatic test_hold();
    logic ok; int n;
    start_op(16'h9ABC, 16'h7654, 1'b0, ok);
    wait_valid(n);
    total++; if (n != 4) begin bad++; $display("FAIL hold_latency got=%0d exp=4", n); end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 16'(i); in_b = 16'h0000; in_cin = 1'b1;
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1 || {out_carry, out_sum} !== 17'h11110 || in_ready !== 1'b0) begin bad++;
        $display("FAIL hold_cycle%0d got valid=%b res=%b_%h ready=%b exp valid=1 res=1_1110 ready=0",
                 i, out_valid, out_carry, out_sum, in_ready); end
    end
    in_a = 16'h0F0F; in_b = 16'h00F1; in_cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin bad++;
      $display("FAIL hold_same_cycle got valid=%b busy=%b ready=%b exp 0 0 1", out_valid, busy, in_ready); end
    total++; if ({out_carry, out_sum} !== 17'h11110) begin bad++;
      $display("FAIL hold_keep_last got=%b_%h exp=1_1110", out_carry, out_sum); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL hold_next_accept got busy=%b exp=1", busy); end
    wait_valid(n);
    total++; if (n != 4 || {out_carry, out_sum} !== 17'h01000) begin bad++;
      $display("FAIL hold_next_result got lat=%0d res=%b_%h exp lat=4 res=0_1000", n, out_carry, out_sum); end
    release_result();
  endtask

  task automatic test_reset_mid();
    logic ok; int n;
    start_op(16'hFFFF, 16'hFFFF, 1'b1, ok);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++;
      $display("FAIL midrst_flags got valid=%b busy=%b exp 0 0", out_valid, busy); end
    total++; if ({out_carry, out_sum} !== 17'h00000) begin bad++;
      $display("FAIL midrst_result got=%b_%h exp=0_0000", out_carry, out_sum); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin bad++;
      $display("FAIL midrst_release got ready=%b busy=%b valid=%b exp 1 0 0", in_ready, busy, out_valid); end
    start_op(16'h0001, 16'h0001, 1'b0, ok);
    wait_valid(n);
    total++; if (n != 4 || {out_carry, out_sum} !== 17'h00002) begin bad++;
      $display("FAIL midrst_next got lat=%0d res=%b_%h exp lat=4 res=0_0002", n, out_carry, out_sum); end
    release_result();
  endtask

`ifdef SUBTRACT_EN
  task automatic test_subtract();
    logic ok; int n;
    in_sub = 1'b1;
    start_op(16'h0005, 16'h0007, 1'b1, ok);
    in_sub = 1'b0;
    wait_valid(n);
    total++; if (n != 4 || {out_carry, out_sum} !== 17'h0FFFE) begin bad++;
      $display("FAIL sub_borrow got lat=%0d res=%b_%h exp lat=4 res=0_fffe", n, out_carry, out_sum); end
    release_result();
    in_sub = 1'b1;
    start_op(16'h0007, 16'h0005, 1'b0, ok);
    in_sub = 1'b0;
    wait_valid(n);
    total++; if (n != 4 || {out_carry, out_sum} !== 17'h10002) begin bad++;
      $display("FAIL sub_noborrow got lat=%0d res=%b_%h exp lat=4 res=1_0002", n, out_carry, out_sum); end
    release_result();
  endtask
`endif

  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    logic         c;
    logic [W:0]   exp;
    int           n;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom); b = W'($urandom); c = 1'($urandom);
      if (i == 0) begin a = 16'hFFFF; b = 16'hFFFF; c = 1'b1; end
      exp = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      in_a = a; in_b = b; in_cin = c;
      total++;
      if (in_ready !== 1'b1) begin
        bad++; $display("FAIL b2b_ready op=%0d got=%b exp=1", i, in_ready); break;
      end
      @(posedge clk); #1;
      in_a = W'($urandom); in_b = W'($urandom); in_cin = ~c;
      wait_valid(n);
      if (n != 4 || {out_carry, out_sum} !== exp) begin
        bad++;
        $display("FAIL b2b_op%0d a=%h b=%h cin=%b got lat=%0d res=%b_%h exp lat=4 res=%b_%h",
                 i, a, b, c, n, out_carry, out_sum, exp[W], exp[W-1:0]);
        break;
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    test_reset();
    test_carry_ripple();
    test_basic_busy();
    test_hold();
    test_reset_mid();
`ifdef SUBTRACT_EN
    test_subtract();
`endif
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
